mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester and the load/store requester of the multicycle core.
- Sits between the control FSM/datapath and the memory model.
- Sequences each access: grant, address/data latch, memory-latency wait, response.
- Acks with a one-cycle pulse plus read data.

Parameters:
- ADDR_W, 64, address width of both requesters and the memory.
- DATA_W, 64, data width; instruction port returns the low 32 bits.
- MEM_LAT, 2, cycles from memory address presentation to valid mem_rdata; legal range 1..15.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- i_req  in  1  fetch request, level, held until i_ack
- i_addr  in  ADDR_W  fetch address
- i_ack  out  1  one-cycle fetch completion pulse
- i_rdata  out  32  fetched word, valid while i_ack=1
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  DATA_W  load data, valid while d_ack=1
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wr  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- One clock domain (CLK). Reset is synchronous and active-high (RST).
- Reset values: all outputs 0, internal latches 0, owner=none, state=IDLE.
- States:
  - IDLE: sample i_req/d_req. If any is high, grant one, latch addr/wdata/we/owner, cnt<=0, go ACCESS.
  - ACCESS: mem_addr/mem_wdata driven from the latches (not the live inputs).
    - mem_wr=1 only when latched we=1 and cnt==0 (exactly one cycle per store).
    - Store: ACCESS lasts 1 cycle, then RESP.
    - Load: ACCESS lasts MEM_LAT cycles, cnt increments each cycle. On the last cycle (cnt==MEM_LAT-1) capture mem_rdata into the response register, then RESP.
  - RESP: pulse the owner's ack for exactly one cycle; rdata outputs hold the captured value. Then go IDLE.
- Latency, grant edge to ack high:
  - Load/fetch: MEM_LAT+1 cycles.
  - Store: 2 cycles.
- A requester deasserts req in the cycle after its ack. If req is still high in IDLE, it is treated as a new request, so back-to-back accesses are allowed. The minimum cycle per access is latency+1.
- Fetch port is read-only; mem_wr never asserts for an instruction grant.
- i_rdata = low 32 bits of the captured word.
- Default arbitration is fixed priority, data over fetch: d_req and i_req both high in IDLE -> data granted, fetch waits.
- Input changes during ACCESS/RESP (addr, wdata, we, req drop) are ignored until the next IDLE. A req dropped before ack still completes its access and acks.
- Never more than one ack high in any cycle. Ack is never issued without a prior grant.
- RST asserted mid-access: next edge forces IDLE, no ack issued, mem_wr=0, response register cleared. A partially issued store has either already written (cnt==0 edge) or not; the arbiter does not retry it.
- busy=1 in ACCESS and RESP.
- In IDLE: mem_wr=0, mem_addr holds the last latched address.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both requests are high in IDLE, grant the requester that was not granted last (1-bit last_owner register, reset value = fetch, so the first contested grant goes to data). Single requests are granted immediately as usual.
- Undefined: fixed data-over-fetch priority, no last_owner register.

Test Plan:
- MEM_LAT=2, i_req with i_addr=0x40, memory word 0x00500093 -> mem_addr=0x40 for 2 cycles, i_ack high exactly 3 cycles after grant, i_rdata=0x00500093, d_ack stays 0.
- d_req, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_wr high exactly 1 cycle with mem_addr=0x100, d_ack 2 cycles after grant; a subsequent load of 0x100 returns 0xDEADBEEF.
- Both requests high in IDLE (i_addr=0x8, load d_addr=0x200) -> data served first, fetch granted the cycle after d_ack, never overlapping acks. With ARB_ROUND_ROBIN_EN, a second contested pair grants fetch first.
- d_addr changed from 0x200 to 0x300 mid-ACCESS -> mem_addr stays 0x200, d_rdata = mem[0x200].
- RST asserted for 1 cycle during a load's wait -> busy=0, no ack issued, all outputs 0 next cycle; a new i_req afterwards completes normally.
- i_req held continuously over 4 fetches, addresses 0x0,0x4,0x8,0xC -> 4 acks spaced MEM_LAT+2 cycles apart, correct data each time.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory signals of the shared memory port
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_wr, busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_wr, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for one single-port memory
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contested requests.
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input logic            CLK,
    input logic            RST,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q;
    logic              owner_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] resp_q;
    logic              wr_q;
    logic              i_ack_q;
    logic              d_ack_q;
    logic              busy_q;
    logic              grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data won the most recent grant; resets to fetch so data wins first contest
    logic last_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_d <= 1'b0;
        end else if (state == IDLE && (bus.d_req || bus.i_req)) begin
            last_d <= grant_d;
        end
    end

    assign grant_d = bus.d_req && (!bus.i_req || !last_d);
`else
    assign grant_d = bus.d_req;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            owner_d <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
            wr_q    <= 1'b0;
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wr_q    <= 1'b0;
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    if (bus.d_req || bus.i_req) begin
                        state   <= ACCESS;
                        busy_q  <= 1'b1;
                        cnt     <= '0;
                        owner_d <= grant_d;
                        if (grant_d) begin
                            addr_q  <= bus.d_addr;
                            wdata_q <= bus.d_wdata;
                            we_q    <= bus.d_we;
                            wr_q    <= bus.d_we;
                        end else begin
                            addr_q <= bus.i_addr;
                            we_q   <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    // strobe was raised on entry, so it covers only the cnt==0 cycle
                    wr_q <= 1'b0;
                    cnt  <= cnt + 4'd1;
                    if (we_q || cnt == LAST) begin
                        if (!we_q) begin
                            resp_q <= bus.mem_rdata;
                        end
                        state   <= RESP;
                        d_ack_q <= owner_d;
                        i_ack_q <= !owner_d;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    wr_q    <= 1'b0;
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wr    = wr_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.i_rdata   = resp_q[31:0];
    assign bus.d_rdata   = resp_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit last_served_d = 1'b0;

    function automatic logic [63:0] init_word(input logic [9:0] a);
        if (a == 10'h040) return 64'h0000_0000_0050_0093;
        return {a, 22'h15a5a5, ~a, 22'h0abcde};
    endfunction

    // memory: one-register read pipeline gives mem_rdata two cycles after address
    logic [63:0] phys_mem [1024];
    bit          phys_wr  [1024];
    logic [63:0] rd_q;
    logic [9:0]  mem_idx;
    assign mem_idx       = bus.mem_addr[9:0];
    assign bus.mem_rdata = rd_q;

    always @(posedge clk) begin
        rd_q <= phys_wr[mem_idx] ? phys_mem[mem_idx] : init_word(mem_idx);
        if (bus.mem_wr) begin
            phys_mem[mem_idx] <= bus.mem_wdata;
            phys_wr[mem_idx]  <= 1'b1;
        end
    end

    logic [63:0] ref_mem [1024];
    bit          ref_wr  [1024];

    function automatic logic [63:0] ref_rd(input logic [9:0] a);
        return ref_wr[a] ? ref_mem[a] : init_word(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_wait();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait_timeout", 64'(n < 50), 64'd1);
    endtask

    task automatic access(input bit is_d, input bit we, input logic [9:0] a,
                          input logic [63:0] wd, input bit scramble, input string tag);
        int ack_k = 0;
        int wr_n = 0;
        int exp_lat;
        bit other = 1'b0;
        bit addr_ok = 1'b1;
        logic [63:0] got;
        logic [63:0] exp;
        exp_lat = we ? 2 : LAT + 1;
        exp = ref_rd(a);
        idle_wait();
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = {54'b0, a}; bus.d_wdata = wd;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = {54'b0, a};
        end
        for (int k = 1; k <= 20 && ack_k == 0; k++) begin
            @(negedge clk);
            if (bus.mem_wr) begin
                wr_n++;
                if (bus.mem_addr !== {54'b0, a} || bus.mem_wdata !== wd) addr_ok = 1'b0;
            end
            if (k < exp_lat && bus.mem_addr !== {54'b0, a}) addr_ok = 1'b0;
            if (is_d ? bus.i_ack : bus.d_ack) other = 1'b1;
            if (scramble && k == 1) begin
                bus.d_addr  = {54'b0, a ^ 10'h100};
                bus.d_wdata = {$urandom, $urandom};
                bus.d_we    = ~bus.d_we;
                bus.i_addr  = 64'($urandom_range(0, 1023));
            end
            if (is_d ? bus.d_ack : bus.i_ack) begin
                ack_k = k;
                got = is_d ? bus.d_rdata : {32'b0, bus.i_rdata};
                if (is_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
            end
        end
        check({tag, "_latency"}, 64'(ack_k), 64'(exp_lat));
        check({tag, "_wr_count"}, 64'(wr_n), 64'(we));
        check({tag, "_addr_latched"}, 64'(addr_ok), 64'd1);
        check({tag, "_other_ack"}, 64'(other), 64'd0);
        if (!we) check({tag, "_rdata"}, got, is_d ? exp : {32'b0, exp[31:0]});
        @(negedge clk);
        check({tag, "_ack_pulse"}, {62'b0, bus.i_ack, bus.d_ack}, 64'd0);
        if (we) begin
            ref_mem[a] = wd;
            ref_wr[a]  = 1'b1;
        end
        last_served_d = is_d;
    endtask

    task automatic contested(input logic [9:0] ia, input logic [9:0] da, input string tag);
        bit exp_first_d;
        int kd = 0;
        int ki = 0;
        bit overlap = 1'b0;
        logic [63:0] gd;
        logic [31:0] gi;
`ifdef ARB_ROUND_ROBIN_EN
        exp_first_d = !last_served_d;
`else
        exp_first_d = 1'b1;
`endif
        idle_wait();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = {54'b0, da};
        bus.i_req = 1'b1; bus.i_addr = {54'b0, ia};
        for (int k = 1; k <= 30 && (kd == 0 || ki == 0); k++) begin
            @(negedge clk);
            if (bus.d_ack && bus.i_ack) overlap = 1'b1;
            if (bus.d_ack && kd == 0) begin kd = k; gd = bus.d_rdata; bus.d_req = 1'b0; end
            if (bus.i_ack && ki == 0) begin ki = k; gi = bus.i_rdata; bus.i_req = 1'b0; end
        end
        check({tag, "_first_ack"}, 64'(exp_first_d ? kd : ki), 64'(LAT + 1));
        check({tag, "_second_ack"}, 64'(exp_first_d ? ki : kd), 64'(2 * LAT + 3));
        check({tag, "_overlap"}, 64'(overlap), 64'd0);
        check({tag, "_d_rdata"}, gd, ref_rd(da));
        check({tag, "_i_rdata"}, {32'b0, gi}, {32'b0, ref_rd(ia) & 64'hffff_ffff});
        last_served_d = !exp_first_d;
        @(negedge clk);
    endtask

    initial begin
        int acks;
        int kk [4];
        int na;
        logic [9:0] fa;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_acks", {62'b0, bus.i_ack, bus.d_ack}, 64'd0);
        check("rst_mem_wr", 64'(bus.mem_wr), 64'd0);
        check("rst_mem_addr", bus.mem_addr, 64'd0);
        check("rst_mem_wdata", bus.mem_wdata, 64'd0);
        check("rst_d_rdata", bus.d_rdata, 64'd0);
        check("rst_i_rdata", 64'(bus.i_rdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        contested(10'h008, 10'h200, "contest1");
        access(1'b0, 1'b0, 10'h040, 64'd0, 1'b0, "fetch_40");
        access(1'b1, 1'b1, 10'h100, 64'h0000_0000_dead_beef, 1'b0, "store_100");
        access(1'b1, 1'b0, 10'h100, 64'd0, 1'b0, "load_100");
        contested(10'h010, 10'h208, "contest2");
        access(1'b1, 1'b0, 10'h200, 64'd0, 1'b1, "load_200_live_change");

        // reset in the middle of a load's wait
        idle_wait();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h123;
        repeat (2) @(negedge clk);
        rst = 1'b1; bus.d_req = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_outs", {61'b0, bus.i_ack, bus.d_ack, bus.mem_wr}, 64'd0);
        check("midrst_mem_addr", bus.mem_addr, 64'd0);
        check("midrst_d_rdata", bus.d_rdata, 64'd0);
        rst = 1'b0;
        last_served_d = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.i_ack || bus.d_ack) acks++;
        end
        check("midrst_no_ack", 64'(acks), 64'd0);
        access(1'b0, 1'b0, 10'h044, 64'd0, 1'b0, "fetch_after_rst");

        // fetch request held across four back-to-back accesses
        idle_wait();
        fa = 10'h000;
        na = 0;
        bus.i_req = 1'b1; bus.i_addr = 64'h0;
        for (int k = 1; k <= 60 && na < 4; k++) begin
            @(negedge clk);
            if (bus.d_ack) check("burst_d_ack", 64'(bus.d_ack), 64'd0);
            if (bus.i_ack) begin
                kk[na] = k;
                check($sformatf("burst_rdata%0d", na), 64'(bus.i_rdata), ref_rd(fa) & 64'hffff_ffff);
                na++;
                fa = fa + 10'd4;
                bus.i_addr = {54'b0, fa};
                if (na == 4) bus.i_req = 1'b0;
            end
        end
        check("burst_ack_count", 64'(na), 64'd4);
        check("burst_first", 64'(kk[0]), 64'(LAT + 1));
        for (int j = 1; j < 4; j++)
            check($sformatf("burst_spacing%0d", j), 64'(kk[j] - kk[j-1]), 64'(LAT + 2));
        last_served_d = 1'b0;

        for (int r = 0; r < 12; r++) begin
            bit rd_port;
            bit rwe;
            rd_port = 1'($urandom_range(0, 1));
            rwe = rd_port & 1'($urandom_range(0, 1));
            access(rd_port, rwe, 10'($urandom_range(0, 1023)), {$urandom, $urandom},
                   1'b1, $sformatf("rand%0d", r));
        end
        contested(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), "contest3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
